// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: FSM states, line geometry
// and the PC field split used by the lookup and fill paths.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    INSTALL = 2'd2
  } state_e;

  localparam int LINE_BITS      = 256;
  localparam int WORDS_PER_LINE = 8;
  localparam int OFFSET_W       = 3;
  // Bits above the 32-byte line offset: index and tag live in here.
  localparam int LINE_ADDR_W    = 27;

  typedef struct packed {
    logic [LINE_ADDR_W-1:0] line_addr;
    logic [OFFSET_W-1:0]    word_off;
  } addr_fields_t;

  // Split a byte PC into line address and word offset; byte lanes are dropped.
  function automatic addr_fields_t split_addr(input logic [31:0] addr);
    addr_fields_t f;
    f.line_addr = addr[31:5];
    f.word_off  = addr[4:2];
    return f;
  endfunction

endpackage

// File: rtl/icache_fetch_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave: the cache; master: IF stage plus instruction memory.
interface icache_fetch_if;

  logic                           fetch_req;
  logic [31:0]                    Instr_address_2IM;
  logic                           flush;
  logic [31:0]                    Instr1_fIM;
  logic [31:0]                    Instr2_fIM;
  logic                           instr_valid;
  logic                           single_fetch;
  logic                           stall;
  logic                           iBlkRead;
  logic [31:0]                    iblk_address;
  logic [icache_pkg::LINE_BITS-1:0] block_read_fIM;
  logic                           iblk_ready;

  modport slave (
    input  fetch_req, Instr_address_2IM, flush, block_read_fIM, iblk_ready,
    output Instr1_fIM, Instr2_fIM, instr_valid, single_fetch, stall,
           iBlkRead, iblk_address
  );

  modport master (
    output fetch_req, Instr_address_2IM, flush, block_read_fIM, iblk_ready,
    input  Instr1_fIM, Instr2_fIM, instr_valid, single_fetch, stall,
           iBlkRead, iblk_address
  );

endinterface

// File: rtl/icache_tag_array.sv
// Valid bits and tags for the direct-mapped cache. Valid bits reset and
// flush-clear; tags are plain storage and are never reset.
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int LINES = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [$clog2(LINES)-1:0]         rd_idx,
  input  logic [LINE_ADDR_W-$clog2(LINES)-1:0] rd_tag,
  output logic                             tag_hit,
  input  logic                             wr_en,
  input  logic [$clog2(LINES)-1:0]         wr_idx,
  input  logic [LINE_ADDR_W-$clog2(LINES)-1:0] wr_tag,
  input  logic                             wr_valid
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = LINE_ADDR_W - IDX_W;

  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_r [LINES];

  // Valid bits: flush wins over a same-cycle install so a flushed fill stays dead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
    end else if (flush) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_idx] <= wr_valid;
    end
  end

  // Tag storage written on install; contents are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_idx] <= wr_tag;
    end
  end

  assign tag_hit = valid_r[rd_idx] & (tag_r[rd_idx] == rd_tag);

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache delivering the PC word and the PC+4 word
// on a hit, with an IDLE/FILL/INSTALL miss engine over the iBlkRead port.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_fetch
  import icache_pkg::*;
#(
  parameter int LINES = 32
) (
  input  logic CLK,
  input  logic RESET,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  icache_fetch_if.slave bus
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = LINE_ADDR_W - IDX_W;

  state_e                 state_r;
  state_e                 next_state_s;
  logic [LINE_ADDR_W-1:0] miss_line_r;
  logic                   iblk_read_r;
  logic                   drop_r;
  logic [LINE_BITS-1:0]   line_buf_r;
  logic [LINE_BITS-1:0]   data_r [LINES];

  addr_fields_t           pc_s;
  logic [IDX_W-1:0]       pc_idx_s;
  logic [TAG_W-1:0]       pc_tag_s;
  logic                   tag_hit_s;
  logic                   idle_s;
  logic                   hit_s;
  logic                   miss_s;
  logic                   install_s;
  logic [LINE_BITS-1:0]   rd_line_s;
  logic [7:0]             lo1_s;
  logic [7:0]             lo2_s;
  logic [31:0]            instr1_s;
  logic [31:0]            instr2_s;
  logic                   single_s;

  assign pc_s      = split_addr(bus.Instr_address_2IM);
  assign pc_idx_s  = pc_s.line_addr[IDX_W-1:0];
  assign pc_tag_s  = pc_s.line_addr[LINE_ADDR_W-1:IDX_W];
  assign idle_s    = (state_r == IDLE);
  assign hit_s     = bus.fetch_req & tag_hit_s & idle_s & ~bus.flush;
  assign miss_s    = bus.fetch_req & ~tag_hit_s & idle_s & ~bus.flush;
  assign install_s = (state_r == INSTALL);

  icache_tag_array #(.LINES(LINES)) u_tags (
    .clk      (CLK),
    .rst_n    (RESET),
    .flush    (bus.flush),
    .rd_idx   (pc_idx_s),
    .rd_tag   (pc_tag_s),
    .tag_hit  (tag_hit_s),
    .wr_en    (install_s),
    .wr_idx   (miss_line_r[IDX_W-1:0]),
    .wr_tag   (miss_line_r[LINE_ADDR_W-1:IDX_W]),
    .wr_valid (~(drop_r | bus.flush))
  );

  // Next-state logic for the miss engine.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (miss_s) next_state_s = FILL;
        else        next_state_s = IDLE;
      end
      FILL: begin
        if (bus.iblk_ready) next_state_s = INSTALL;
        else                next_state_s = FILL;
      end
      INSTALL: next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, registered block-read request, miss address and flush-discard flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r     <= IDLE;
      iblk_read_r <= 1'b0;
      miss_line_r <= '0;
      drop_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      iblk_read_r <= (next_state_s == FILL);
      if (miss_s) begin
        miss_line_r <= pc_s.line_addr;
      end
      if (idle_s) begin
        drop_r <= 1'b0;
      end else if (bus.flush) begin
        drop_r <= 1'b1;
      end
    end
  end

  // Line capture on the memory handshake and data-array install; not reset.
  always_ff @(posedge CLK) begin
    if ((state_r == FILL) && bus.iblk_ready) begin
      line_buf_r <= bus.block_read_fIM;
    end
    if (install_s) begin
      data_r[miss_line_r[IDX_W-1:0]] <= line_buf_r;
    end
  end

  assign rd_line_s = data_r[pc_idx_s];
  assign lo1_s     = {pc_s.word_off, 5'd0};
  assign lo2_s     = {pc_s.word_off + 3'd1, 5'd0};

  // Hit-path word select; everything reads zero unless this cycle hits.
  always_comb begin
    instr1_s = 32'd0;
    instr2_s = 32'd0;
    single_s = 1'b0;
    if (hit_s) begin
      instr1_s = rd_line_s[lo1_s +: 32];
      if (pc_s.word_off == 3'd7) begin
        single_s = 1'b1;
      end else begin
        instr2_s = rd_line_s[lo2_s +: 32];
      end
    end else begin
      instr1_s = 32'd0;
      instr2_s = 32'd0;
      single_s = 1'b0;
    end
  end

  assign bus.Instr1_fIM   = instr1_s;
  assign bus.Instr2_fIM   = instr2_s;
  assign bus.instr_valid  = hit_s;
  assign bus.single_fetch = single_s;
  assign bus.stall        = miss_s | ~idle_s;
  assign bus.iBlkRead     = iblk_read_r;
  assign bus.iblk_address = {miss_line_r, 5'd0};

`ifdef ICACHE_STATS_EN
  // Hit and miss event counters, cleared by flush, wrapping at 2^32.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else if (bus.flush) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (hit_s)  hit_count  <= hit_count + 32'd1;
      if (miss_s) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: cold miss, hits, line-end single fetch,
// flush, conflict eviction, flush during fill, reset mid-fill, and counters.
module tb_icache_fetch;

  logic CLK;
  logic RESET;
  icache_fetch_if bus();
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_fetch #(.LINES(32)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
`ifdef ICACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .bus        (bus)
  );

  typedef struct {
    logic [31:0] i1;
    logic [31:0] i2;
    logic        sf;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  // Memory image: line 0x40 holds 0x1000_0000+k, others derive from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] line, input int k);
    if (line == 32'h40) return 32'h1000_0000 + 32'(k);
    return 32'h2000_0000 + (line << 4) + 32'(k);
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] line);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = mem_word(line, k);
    return l;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr);
    bus.fetch_req = 1'b1;
    bus.Instr_address_2IM = addr;
    #1;
  endtask

  // One hit cycle: expectation pushed with the stimulus, popped against the outputs.
  task automatic hit_step(input string tag, input logic [31:0] addr);
    exp_t e;
    logic [31:0] line;
    int off;
    line = addr & 32'hFFFF_FFE0;
    off = int'(addr[4:2]);
    e.i1 = mem_word(line, off);
    e.i2 = (off == 7) ? 32'd0 : mem_word(line, off + 1);
    e.sf = (off == 7);
    sb_q.push_back(e);
    drive(addr);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    check({tag, "_stall"}, 32'(bus.stall), 32'd0);
    e = sb_q.pop_front();
    check({tag, "_i1"}, bus.Instr1_fIM, e.i1);
    check({tag, "_i2"}, bus.Instr2_fIM, e.i2);
    check({tag, "_single"}, 32'(bus.single_fetch), 32'(e.sf));
    tick();
  endtask

  // Full miss sequence with the memory answering after 'latency' FILL cycles.
  task automatic do_miss(input string tag, input logic [31:0] addr, input int latency,
                         input bit flush_mid);
    logic [31:0] line;
    line = addr & 32'hFFFF_FFE0;
    drive(addr);
    check({tag, "_miss_stall"}, 32'(bus.stall), 32'd1);
    check({tag, "_miss_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_miss_rd"}, 32'(bus.iBlkRead), 32'd0);
    tick();
    check({tag, "_rd"}, 32'(bus.iBlkRead), 32'd1);
    check({tag, "_addr"}, bus.iblk_address, line);
    check({tag, "_fill_stall"}, 32'(bus.stall), 32'd1);
    for (int i = 0; i < latency - 1; i++) begin
      if (flush_mid && i == 0) bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check({tag, "_rd_hold"}, 32'(bus.iBlkRead), 32'd1);
      check({tag, "_addr_hold"}, bus.iblk_address, line);
    end
    bus.iblk_ready = 1'b1;
    bus.block_read_fIM = mem_line(line);
    tick();
    bus.iblk_ready = 1'b0;
    bus.block_read_fIM = '0;
    #1;
    check({tag, "_inst_rd"}, 32'(bus.iBlkRead), 32'd0);
    check({tag, "_inst_stall"}, 32'(bus.stall), 32'd1);
    tick();
  endtask

  initial begin
    RESET = 1'b0;
    bus.fetch_req = 1'b0;
    bus.Instr_address_2IM = 32'd0;
    bus.flush = 1'b0;
    bus.iblk_ready = 1'b0;
    bus.block_read_fIM = '0;
    tick();
    tick();
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_rd", 32'(bus.iBlkRead), 32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_i1", bus.Instr1_fIM, 32'd0);
    check("rst_i2", bus.Instr2_fIM, 32'd0);
    check("rst_addr", bus.iblk_address, 32'd0);
    check("rst_single", 32'(bus.single_fetch), 32'd0);
    RESET = 1'b1;
    #1;
    check("noreq_stall", 32'(bus.stall), 32'd0);
    tick();

    // Cold miss, then hits across the line including the last word.
    do_miss("cold", 32'h40, 3, 1'b0);
    hit_step("hit40", 32'h40);
    hit_step("hit44", 32'h44);
    hit_step("hit58", 32'h58);
    hit_step("hit5c", 32'h5C);

    // Flush in IDLE suppresses hit and miss, then the line is gone.
    bus.flush = 1'b1;
    drive(32'h40);
    check("flush_valid", 32'(bus.instr_valid), 32'd0);
    check("flush_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.flush = 1'b0;
    do_miss("postflush", 32'h40, 2, 1'b0);
    hit_step("refill40", 32'h48);

    // Conflict eviction: 0x440 shares index with 0x40.
    do_miss("evict", 32'h440, 4, 1'b0);
    hit_step("hit440", 32'h44C);
    do_miss("re40", 32'h40, 3, 1'b0);
    hit_step("hit40b", 32'h50);

    // Flush during FILL: handshake completes but the line is discarded.
    do_miss("fillflush", 32'h80, 3, 1'b1);
    do_miss("fillagain", 32'h80, 3, 1'b0);
    hit_step("hit80", 32'h84);

`ifdef ICACHE_STATS_EN
    bus.fetch_req = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    check("stats_clr_hit", hit_count, 32'd0);
    check("stats_clr_miss", miss_count, 32'd0);
    do_miss("stats", 32'h40, 3, 1'b0);
    hit_step("st0", 32'h40);
    hit_step("st1", 32'h44);
    hit_step("st2", 32'h48);
    hit_step("st3", 32'h4C);
    hit_step("st4", 32'h50);
    bus.fetch_req = 1'b0;
    #1;
    check("stats_hit", hit_count, 32'd5);
    check("stats_miss", miss_count, 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    check("stats_flush_hit", hit_count, 32'd0);
    check("stats_flush_miss", miss_count, 32'd0);
`endif

    // Reset in the middle of a fill.
    drive(32'hC0);
    tick();
    check("rmf_rd_before", 32'(bus.iBlkRead), 32'd1);
    bus.fetch_req = 1'b0;
    RESET = 1'b0;
    #1;
    check("rmf_rd", 32'(bus.iBlkRead), 32'd0);
    check("rmf_stall", 32'(bus.stall), 32'd0);
    check("rmf_addr", bus.iblk_address, 32'd0);
    tick();
    RESET = 1'b1;
    bus.iblk_ready = 1'b1;
    bus.block_read_fIM = mem_line(32'hC0);
    tick();
    bus.iblk_ready = 1'b0;
    bus.block_read_fIM = '0;
    #1;
    check("rmf_ignore_stall", 32'(bus.stall), 32'd0);
    check("rmf_ignore_rd", 32'(bus.iBlkRead), 32'd0);
    do_miss("rmf_again", 32'hC0, 3, 1'b0);
    hit_step("hitC0_end", 32'hDC);
    do_miss("rmf_lost80", 32'h80, 2, 1'b0);
    hit_step("hit80b", 32'h80);

    bus.fetch_req = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped instruction cache between the IF stage and instruction memory.
- Serves IF two consecutive instruction words per cycle on a hit: the word at the PC and the word at PC+4.
- On a miss, stalls IF via `stall`, fetches one 256-bit line over the iBlkRead block interface, installs it, then resumes.

Parameters:
- LINES, 32, number of cache lines (power of two, ≥2)
- IDX_W, $clog2(LINES), index width (derived; not overridden)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous reset, active-low
- fetch_req  in  1  IF requests instructions this cycle
- Instr_address_2IM  in  32  byte PC from IF; bits [1:0] ignored
- flush  in  1  invalidate all lines
- Instr1_fIM  out  32  word at PC
- Instr2_fIM  out  32  word at PC+4
- instr_valid  out  1  Instr1_fIM valid (hit)
- single_fetch  out  1  Instr2_fIM not valid (PC word offset == 7)
- stall  out  1  freeze IF/ID (miss in progress)
- iBlkRead  out  1  block read request to instruction memory
- iblk_address  out  32  line-aligned address, bits [4:0] = 0
- block_read_fIM  in  256  returned line; word k at bits [32k+31:32k]
- iblk_ready  in  1  one-cycle pulse: block_read_fIM valid

Behaviour:
- Address split:
  - word offset = addr[4:2]
  - index = addr[5+IDX_W-1:5]
  - tag = addr[31:5+IDX_W]
- Storage: per line a valid bit, a tag, and 256 data bits, all in flops.
- Hit path is combinational. Hit = fetch_req & valid[idx] & tag match & state==IDLE & !flush.
- On a hit, in the same cycle:
  - instr_valid=1
  - Instr1 = word[off]
  - Instr2 = word[off+1] when off<7; otherwise Instr2=0 and single_fetch=1
- While instr_valid=0: Instr1=Instr2=0 and single_fetch=0.
- State machine:
  - IDLE:
    - Miss when fetch_req & !hit & !flush.
    - On a miss: stall=1 combinationally in the same cycle, latch miss address, go to FILL.
  - FILL:
    - iBlkRead=1 and iblk_address = {miss_tag, miss_idx, 5'b0}, held stable until iblk_ready.
    - On iblk_ready: capture block_read_fIM, go to INSTALL.
  - INSTALL:
    - One cycle: write data, tag and valid=1 into the line; stall=1; go to IDLE.
    - IF re-presents the PC, which then hits. Miss penalty = memory latency + 2 cycles.
- stall=1 in FILL and INSTALL, and in the IDLE miss cycle.
- iBlkRead is registered: it rises the cycle after the miss is detected and drops in the cycle after iblk_ready.
- flush:
  - All valid bits clear on the next edge.
  - flush in IDLE suppresses both hit and miss for that cycle.
  - flush during FILL/INSTALL: the fill completes its handshake, but INSTALL does not set valid (line discarded).
- iblk_ready outside FILL is ignored.
- fetch_req=0 in IDLE: no action; stall=0.
- Reset (asynchronous, RESET=0), also mid-fill:
  - state=IDLE, all valid=0, iBlkRead=0, stall=0, instr_valid=0.
  - Instr1, Instr2 and iblk_address = 0.
  - Tags and data are not reset.
- Replacement: the new line overwrites the indexed line unconditionally.

Optional Feature:
- ICACHE_STATS_EN
- When defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments each hit cycle; miss_count increments each IDLE→FILL transition.
  - Both wrap at 2^32, reset to 0, and are cleared by flush.
- When undefined: no ports and no counter logic.

Decomposition:
- Shared package icache_pkg: state enum (IDLE, FILL, INSTALL), LINE_BITS=256, WORDS_PER_LINE=8, OFFSET_W=3, and an address-field extraction function.
- One sub-module: icache_tag_array (valid+tag storage, lookup compare, flush clear).
- Data array and FSM stay in the top.

Test Plan:
- Cold miss:
  - Stimulus: after reset, fetch_req=1 with PC=0x0000_0040; memory returns a line with word k = 0x1000_0000+k after 3 cycles.
  - Response: stall rises in the same cycle; iBlkRead rises the next cycle with iblk_address=0x40; after INSTALL, Instr1=0x1000_0000, Instr2=0x1000_0001, instr_valid=1, stall=0.
- Line-end single fetch:
  - Stimulus: PC=0x0000_005C, line resident.
  - Response: Instr1=0x1000_0007, single_fetch=1, Instr2=0.
- Conflict eviction (LINES=32):
  - Stimulus: fill 0x40, then request 0x440.
  - Response: miss with iblk_address=0x440; a re-request of 0x40 misses again.
- Flush during FILL:
  - Stimulus: assert flush while iBlkRead=1.
  - Response: fill completes; the following fetch of the same PC misses again.
- Reset mid-fill:
  - Stimulus: drive RESET low during FILL.
  - Response: iBlkRead=0 and stall=0 immediately (asynchronous); a later iblk_ready is ignored; the next fetch misses.
- ICACHE_STATS_EN:
  - Stimulus: 1 miss followed by 5 hits.
  - Response: miss_count=1, hit_count=5; flush returns both to 0.
